// File: rtl/layer_collector_if.sv
// ---------------------------------------------------------------------------
// layer_collector_if : control, capture, drain and result signals of layer_collector
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface layer_collector_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 3
);
  logic                         start;
  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic [IDX_WIDTH-1:0]         out_idx;
  logic                         result_valid;
  logic signed [DATA_WIDTH-1:0] max_val;
  logic [IDX_WIDTH-1:0]         argmax_idx;
  logic                         drain_done;
  logic                         busy;
  logic                         err_drop;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  out_valid, out_data, out_idx, result_valid, max_val, argmax_idx,
           drain_done, busy, err_drop
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output out_valid, out_data, out_idx, result_valid, max_val, argmax_idx,
           drain_done, busy, err_drop
  );
endinterface

`default_nettype wire

// File: rtl/layer_collector.sv
// ---------------------------------------------------------------------------
// layer_collector : buffers one layer of neuron results, tracks argmax, drains in order
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module layer_collector #(
  parameter int NUM_NEURONS = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int IDX_WIDTH   = 3
) (
  input  logic               clk,
  input  logic               rstn,
  layer_collector_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

  state_t                       state, state_nxt;
  logic [IDX_WIDTH-1:0]         wr_cnt;
  logic [IDX_WIDTH-1:0]         rd_ptr;
  logic signed [DATA_WIDTH-1:0] mem [NUM_NEURONS];
  logic signed [DATA_WIDTH-1:0] max_val;
  logic [IDX_WIDTH-1:0]         argmax_idx;
  logic                         result_valid;
  logic                         out_valid;
  logic                         drain_done;
  logic                         busy;
  logic                         err_drop;

  logic arm, capture, last_capture, handshake, last_handshake, drop, take_max;

  always_comb begin
    state_nxt      = state;
    arm            = 1'b0;
    capture        = 1'b0;
    last_capture   = 1'b0;
    handshake      = 1'b0;
    last_handshake = 1'b0;
    drop           = 1'b0;
    case (state)
      IDLE: begin
        drop = bus.in_valid;
        if (bus.start) begin
          arm       = 1'b1;
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.in_valid) begin
          capture = 1'b1;
          if (wr_cnt == LAST_IDX) begin
            last_capture = 1'b1;
            state_nxt    = DRAIN;
          end
        end
      end
      DRAIN: begin
        drop = bus.in_valid;
        if (out_valid && bus.out_ready) begin
          handshake = 1'b1;
          if (rd_ptr == LAST_IDX) begin
            last_handshake = 1'b1;
            state_nxt      = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // First sample of a layer always seeds the max; later ones need strictly greater, so ties keep the lower index
  assign take_max = capture && ((wr_cnt == '0) || (bus.in_data > max_val));

  always_ff @(posedge clk) begin
    if (rstn) begin
      state        <= IDLE;
      wr_cnt       <= '0;
      rd_ptr       <= '0;
      max_val      <= '0;
      argmax_idx   <= '0;
      result_valid <= 1'b0;
      out_valid    <= 1'b0;
      drain_done   <= 1'b0;
      busy         <= 1'b0;
      err_drop     <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt != IDLE);
      out_valid  <= (state_nxt == DRAIN);
      drain_done <= last_handshake;

      if (arm) begin
        wr_cnt       <= '0;
        result_valid <= 1'b0;
      end

      // A drop in the same cycle as an accepted start leaves the flag set
      if (drop) begin
        err_drop <= 1'b1;
      end else if (arm) begin
        err_drop <= 1'b0;
      end

      if (capture) begin
        mem[wr_cnt] <= bus.in_data;
        wr_cnt      <= last_capture ? '0 : wr_cnt + 1'b1;
      end
      if (take_max) begin
        max_val    <= bus.in_data;
        argmax_idx <= wr_cnt;
      end
      if (last_capture) begin
        result_valid <= 1'b1;
        rd_ptr       <= '0;
      end

      if (handshake) begin
        rd_ptr <= last_handshake ? '0 : rd_ptr + 1'b1;
      end
    end
  end

  assign bus.out_valid    = out_valid;
  assign bus.out_data     = mem[rd_ptr];
  assign bus.out_idx      = rd_ptr;
  assign bus.result_valid = result_valid;
  assign bus.max_val      = max_val;
  assign bus.argmax_idx   = argmax_idx;
  assign bus.drain_done   = drain_done;
  assign bus.busy         = busy;
  assign bus.err_drop     = err_drop;

endmodule

`default_nettype wire

// File: tb/tb_layer_collector.sv
// ---------------------------------------------------------------------------
// tb_layer_collector : randomized self-checking bench for layer_collector
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_layer_collector;
  localparam int N  = 8;
  localparam int DW = 16;
  localparam int IW = 3;

  typedef logic signed [DW-1:0] data_t;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  layer_collector_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

  layer_collector #(.NUM_NEURONS(N), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int bp_pat [11] = '{1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: first occurrence of the largest signed value
  task automatic ref_argmax(input data_t s[N], output data_t m, output int idx);
    m   = s[0];
    idx = 0;
    for (int i = 1; i < N; i++) begin
      if (s[i] > m) begin
        m   = s[i];
        idx = i;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    total++;
    if ({bus.out_valid, bus.out_data, bus.out_idx, bus.result_valid, bus.max_val,
         bus.argmax_idx, bus.drain_done, bus.busy, bus.err_drop} !== '0) begin
      bad++;
      $display("FAIL %s outputs: ov=%b od=%0d oi=%0d rv=%b max=%0d arg=%0d dd=%b busy=%b err=%b, required all 0",
               tag, bus.out_valid, bus.out_data, bus.out_idx, bus.result_valid, bus.max_val,
               bus.argmax_idx, bus.drain_done, bus.busy, bus.err_drop);
    end
  endtask

  // Full layer: start, capture with random gaps, drain with given ready behaviour
  task automatic do_layer(input data_t s[N], input int gap_max, input int ready_pct,
                          input bit use_pat, input bit drop_in_drain, input int start_at);
    data_t exp_max;
    int    exp_idx;
    int    got;
    int    cyc;
    bit    rdy;
    ref_argmax(s, exp_max, exp_idx);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b1 || bus.result_valid !== 1'b0 || bus.err_drop !== 1'b0) begin
      bad++;
      $display("FAIL start_arm: busy=%b rv=%b err=%b, required 1 0 0", bus.busy, bus.result_valid, bus.err_drop);
    end

    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        tick();
        total++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
          bad++;
          $display("FAIL collect_gap: busy=%b ov=%b, required 1 0", bus.busy, bus.out_valid);
        end
      end
      if (i == start_at) begin
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = s[i];
      tick();
      bus.in_valid = 1'b0;
    end

    total++;
    if (bus.result_valid !== 1'b1 || bus.max_val !== exp_max || bus.argmax_idx !== IW'(exp_idx)) begin
      bad++;
      $display("FAIL argmax: rv=%b max=%0d idx=%0d, required 1 %0d %0d",
               bus.result_valid, bus.max_val, bus.argmax_idx, exp_max, exp_idx);
    end

    got = 0;
    cyc = 0;
    while (got < N) begin
      if (cyc >= 500) begin
        total++;
        bad++;
        $display("FAIL drain_timeout: got=%0d handshakes, required %0d", got, N);
        break;
      end
      rdy = use_pat ? ((cyc < 11) ? bp_pat[cyc] != 0 : 1'b1)
                    : ($urandom_range(0, 99) < ready_pct);
      bus.out_ready = rdy;
      bus.in_valid  = drop_in_drain && (cyc == 2);
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_idx !== IW'(got) || bus.out_data !== s[got]) begin
        bad++;
        $display("FAIL drain_beat: ov=%b idx=%0d data=%0d, required 1 %0d %0d",
                 bus.out_valid, bus.out_idx, bus.out_data, got, s[got]);
      end
      tick();
      bus.in_valid = 1'b0;
      if (rdy) got++;
      cyc++;
    end
    bus.out_ready = 1'b0;

    total++;
    if (bus.drain_done !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain_end: dd=%b busy=%b ov=%b, required 1 0 0", bus.drain_done, bus.busy, bus.out_valid);
    end
    tick();
    total++;
    if (bus.drain_done !== 1'b0 || bus.result_valid !== 1'b1 || bus.max_val !== exp_max
        || bus.argmax_idx !== IW'(exp_idx)) begin
      bad++;
      $display("FAIL post_drain_hold: dd=%b rv=%b max=%0d idx=%0d, required 0 1 %0d %0d",
               bus.drain_done, bus.result_valid, bus.max_val, bus.argmax_idx, exp_max, exp_idx);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    rstn = 1'b1;
    tick();
    tick();
    rstn = 1'b0;
    check_all_zero("reset");
  endtask

  task automatic test_basic();
    data_t s[N] = '{16'sd5, 16'sd0, 16'sd12, 16'sd3, 16'sd12, 16'sd7, 16'sd1, 16'sd2};
    do_layer(s, 0, 100, 1'b0, 1'b0, -1);
  endtask

  task automatic test_negative();
    data_t a[N] = '{-16'sd3, -16'sd7, -16'sd4, -16'sd9, -16'sd8, -16'sd5, -16'sd6, -16'sd10};
    data_t b[N] = '{-16'sd8, -16'sd7, -16'sd6, -16'sd5, -16'sd4, -16'sd3, -16'sd2, -16'sd1};
    do_layer(a, 0, 100, 1'b0, 1'b0, -1);
    do_layer(b, 0, 100, 1'b0, 1'b0, -1);
  endtask

  task automatic test_backpressure();
    data_t s[N];
    for (int i = 0; i < N; i++) s[i] = data_t'(int'($urandom_range(0, 200)) - 100);
    do_layer(s, 0, 100, 1'b1, 1'b0, -1);
  endtask

  task automatic test_gapped();
    data_t s[N] = '{16'sd5, 16'sd0, 16'sd12, 16'sd3, 16'sd12, 16'sd7, 16'sd1, 16'sd2};
    do_layer(s, 3, 100, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random();
    data_t s[N];
    for (int l = 0; l < 8; l++) begin
      for (int i = 0; i < N; i++) s[i] = data_t'(int'($urandom_range(0, 40)) - 20);
      if (l == 7) s[0] = 16'sh8000;
      do_layer(s, 3, 60, 1'b0, 1'b0, -1);
    end
  endtask

  task automatic test_drop();
    data_t s[N];
    for (int i = 0; i < N; i++) s[i] = data_t'(int'($urandom_range(0, 2000)) - 1000);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'sd99;
    tick();
    bus.in_valid = 1'b0;
    total++;
    if (bus.err_drop !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_drop: err=%b busy=%b, required 1 0", bus.err_drop, bus.busy);
    end
    do_layer(s, 1, 80, 1'b0, 1'b1, -1);
    total++;
    if (bus.err_drop !== 1'b1) begin
      bad++;
      $display("FAIL drain_drop: err=%b, required 1", bus.err_drop);
    end
    for (int i = 0; i < N; i++) s[i] = data_t'(int'($urandom_range(0, 2000)) - 1000);
    do_layer(s, 1, 100, 1'b0, 1'b0, 3);
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    total++;
    if (bus.err_drop !== 1'b1 || bus.busy !== 1'b1 || bus.result_valid !== 1'b0) begin
      bad++;
      $display("FAIL start_with_drop: err=%b busy=%b rv=%b, required 1 1 0",
               bus.err_drop, bus.busy, bus.result_valid);
    end
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
  endtask

  task automatic test_reset_mid();
    data_t s[N];
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = data_t'(int'($urandom_range(1, 500)));
      tick();
    end
    bus.in_valid = 1'b0;
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
    check_all_zero("reset_mid");
    for (int i = 0; i < N; i++) s[i] = data_t'(int'($urandom_range(0, 2000)) - 1000);
    do_layer(s, 2, 70, 1'b0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_backpressure();
    test_gapped();
    test_random();
    test_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/layer_collector.md
Name: layer_collector

Overview:
Downstream stage of the neuron array. It captures one quantized, ReLU'd neuron result per completion pulse into an on-chip register buffer, and tracks the running maximum and its index (argmax). Once a full layer of NUM_NEURONS results is held, it streams them out in index order over a valid/ready interface to the next layer's input loader. It also exposes the argmax result for classification.

Parameters:
NUM_NEURONS, 8, neurons per layer (number of results collected before draining); must be >= 2.
DATA_WIDTH, 16, signed width of each neuron result.
IDX_WIDTH, 3, index width; must satisfy 2**IDX_WIDTH >= NUM_NEURONS.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rstn  input  1  synchronous, active-high reset (port name retained per codebase; asserted = 1).
start  input  1  one-cycle pulse; arms collection of a new layer.
in_valid  input  1  neuron done pulse; in_data is valid this cycle.
in_data  input  DATA_WIDTH  signed neuron result.
out_valid  output  1  drain stream valid.
out_ready  input  1  downstream accepts out_data when high with out_valid.
out_data  output  DATA_WIDTH  signed buffered result being drained.
out_idx  output  IDX_WIDTH  index of out_data.
result_valid  output  1  max_val/argmax_idx hold a completed layer.
max_val  output  DATA_WIDTH  signed maximum of the collected layer.
argmax_idx  output  IDX_WIDTH  index of max_val.
drain_done  output  1  one-cycle pulse after the last drain handshake.
busy  output  1  high in COLLECT or DRAIN.
err_drop  output  1  sticky; set when an in_valid sample is dropped.

Behaviour:
- Reset (rstn=1 at an edge): state=IDLE; wr_cnt=0, rd_ptr=0. All outputs are 0: out_valid, out_data, out_idx, result_valid, max_val, argmax_idx, drain_done, busy, err_drop. Buffer contents are cleared to 0. Reset overrides every other input, including mid-COLLECT or mid-DRAIN.
- FSM states: IDLE, COLLECT, DRAIN.
- IDLE:
  - start=1 -> COLLECT next cycle. Sets wr_cnt=0, clears result_valid and err_drop.
  - in_valid=1 is dropped and sets err_drop. If start and in_valid are both high in the same cycle, start is taken, the sample is dropped, and err_drop ends at 1 (set wins over clear).
- COLLECT:
  - Each in_valid=1 cycle writes buf[wr_cnt]=in_data and increments wr_cnt. Gaps of any length between samples are allowed.
  - Max update: the sample at wr_cnt=0 loads max_val/argmax_idx unconditionally. Later samples replace them only if strictly greater (signed compare). Ties keep the lower index.
  - On the sample with wr_cnt=NUM_NEURONS-1: go to DRAIN at the same edge, set result_valid=1 and rd_ptr=0.
  - start is ignored in this state.
- DRAIN:
  - out_valid=1 throughout; out_data=buf[rd_ptr], out_idx=rd_ptr. The first out_valid cycle is the cycle after the final capture edge.
  - Handshake when out_valid & out_ready: rd_ptr increments.
  - While out_valid & !out_ready, out_data and out_idx are held stable.
  - Handshake at rd_ptr=NUM_NEURONS-1: go to IDLE, drain_done=1 for exactly one cycle, out_valid=0.
  - in_valid in DRAIN is dropped and sets err_drop. start is ignored.
- result_valid, max_val and argmax_idx stay held after DRAIN until the next accepted start or reset.
- busy = (state != IDLE), registered with the state.
- Latency: at least NUM_NEURONS capture cycles, then at least NUM_NEURONS drain cycles. Minimum from start to drain_done is 2*NUM_NEURONS+2 cycles with continuous in_valid and out_ready.
- Signed arithmetic only; no saturation or rounding is needed (values pass through unchanged).

Test Plan:
- Basic layer, tie handling: reset, start, then 8 consecutive in_valid with 5,0,12,3,12,7,1,2, out_ready=1 -> result_valid=1 the cycle after the 8th sample, max_val=12, argmax_idx=2. out_data streams 5,0,12,3,12,7,1,2 with out_idx 0..7, one per cycle. drain_done pulses once, then busy=0.
- Negative values, index-0 max: samples -3,-7,-4,-9,-8,-5,-6,-10 -> max_val=-3, argmax_idx=0. Samples -8,-7,-6,-5,-4,-3,-2,-1 -> max_val=-1, argmax_idx=7.
- Backpressure: during drain, out_ready pattern 1,0,0,1,0,1,1,1,1,1,1 -> out_data and out_idx held over the 0 cycles. Exactly 8 handshakes occur, in order, with no duplicates or skips.
- Gapped input: samples arrive with 0-3 idle cycles between in_valid pulses -> same buffer contents and argmax as back-to-back input. busy stays high throughout.
- Drop error: in_valid in IDLE before start -> err_drop=1, nothing captured. start clears err_drop. in_valid during DRAIN -> err_drop=1 and the drained data is unchanged. start during COLLECT -> ignored, wr_cnt is not reset.
- Reset mid-operation: assert rstn after 4 samples -> next cycle all outputs 0 and state IDLE. A following full layer collects and drains correctly from index 0.
